// File: rtl/nexi_uart_rx_fifo.sv
// Purpose: receive buffer between the UART receiver handshake and the CPU read port (16 x 8 bits by default).
// Latency: rx_data_ready rise -> byte on rd_data and empty=0 after 1 clk edge; pops take effect at the edge.
// Backpressure: none toward the receiver; bytes arriving while full are acked, dropped and flagged in overrun.
// Optional irq output enabled by defining NEXI_UART_RX_FIFO_IRQ_EN.
module nexi_uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int IRQ_LEVEL  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_data_ready,
    output logic                  rx_read_ack,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun,
    input  logic                  ovr_clr
`ifdef NEXI_UART_RX_FIFO_IRQ_EN
    ,
    output logic                  irq
`endif
);

    localparam int              DEPTH   = 1 << DEPTH_LOG2;
    localparam int              CW      = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t                  state;
    logic [7:0]              mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wptr;
    logic [DEPTH_LOG2-1:0]   rptr;

    logic                    push_req;
    logic                    pop;
    logic                    push_ok;
    logic                    drop;
    logic [CW-1:0]           count_nxt;
    logic                    overrun_nxt;

    // Show-ahead read: head entry is always presented.
    assign rd_data = mem[rptr];

    // Push/pop qualification and next-state of the fill level and overrun flag.
    always_comb begin
        push_req    = (state == S_IDLE) && rx_data_ready;
        pop         = rd_en && !empty;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        push_ok     = push_req && (!full || pop);
        drop        = push_req && full && !pop;
        count_nxt   = count;
        if (push_ok && !pop) begin
            count_nxt = count + 1'b1;
        end else if (!push_ok && pop) begin
            count_nxt = count - 1'b1;
        end
        // A drop wins over a simultaneous clear so no loss goes unreported.
        overrun_nxt = drop | (overrun & ~ovr_clr);
    end

    // Four-phase handshake with the receiver: one push per data_ready assertion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            rx_read_ack <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_data_ready) begin
                        rx_read_ack <= 1'b1;
                        state       <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!rx_data_ready) begin
                        rx_read_ack <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    rx_read_ack <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= rx_data;
        end
    end

    // Pointers, registered flags and sticky overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            count   <= count_nxt;
            empty   <= (count_nxt == '0);
            full    <= (count_nxt == DEPTH_C);
            overrun <= overrun_nxt;
        end
    end

`ifdef NEXI_UART_RX_FIFO_IRQ_EN
    localparam logic [CW-1:0] IRQ_LVL_C = CW'(IRQ_LEVEL);

    // Level interrupt tracking the next-cycle fill level and overrun state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= (count_nxt >= IRQ_LVL_C) || overrun_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_nexi_uart_rx_fifo.sv
// Purpose: directed bench for nexi_uart_rx_fifo (reset, handshake, fill/overrun, wrap, simultaneous ops, irq).
// Latency: inputs driven 1 time unit after a rising edge; outputs sampled 1 time unit after the next edge.
// Backpressure: the bench plays the UART receiver and CPU; no stalls expected from the DUT.
module tb_nexi_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_data_ready;
    logic       rx_read_ack;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       ovr_clr;
`ifdef NEXI_UART_RX_FIFO_IRQ_EN
    logic       irq;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model [$];
    int         max_cnt;

    nexi_uart_rx_fifo #(
        .DEPTH_LOG2 (4),
        .IRQ_LEVEL  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_data_ready (rx_data_ready),
        .rx_read_ack   (rx_read_ack),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .empty         (empty),
        .full          (full),
        .count         (count),
        .overrun       (overrun),
        .ovr_clr       (ovr_clr)
`ifdef NEXI_UART_RX_FIFO_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full receiver transfer; the model only keeps bytes that fit.
    task automatic push_byte(input logic [7:0] b, input string tag);
        rx_data       = b;
        rx_data_ready = 1'b1;
        tick();
        chk({tag, "_ack_hi"}, {31'd0, rx_read_ack}, 32'd1);
        rx_data_ready = 1'b0;
        tick();
        chk({tag, "_ack_lo"}, {31'd0, rx_read_ack}, 32'd0);
        if (model.size() < 16) model.push_back(b);
    endtask

    task automatic pop_byte(input string tag);
        logic [7:0] exp;
        exp = model.pop_front();
        chk(tag, {24'd0, rd_data}, {24'd0, exp});
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        rx_data       = 8'h00;
        rx_data_ready = 1'b0;
        rd_en         = 1'b0;
        ovr_clr       = 1'b0;
        tick();
        tick();
        chk("rst_ack",     {31'd0, rx_read_ack}, 32'd0);
        chk("rst_count",   {27'd0, count},       32'd0);
        chk("rst_empty",   {31'd0, empty},       32'd1);
        chk("rst_full",    {31'd0, full},        32'd0);
        chk("rst_overrun", {31'd0, overrun},     32'd0);
        rst = 1'b0;
        tick();

        // T1: reset asserted while in S_ACK with three bytes stored
        push_byte(8'h11, "t1_p0");
        push_byte(8'h22, "t1_p1");
        rx_data       = 8'h33;
        rx_data_ready = 1'b1;
        tick();
        chk("t1_ack_before", {31'd0, rx_read_ack}, 32'd1);
        chk("t1_cnt_before", {27'd0, count},       32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_ack",     {31'd0, rx_read_ack}, 32'd0);
        chk("t1_count",   {27'd0, count},       32'd0);
        chk("t1_empty",   {31'd0, empty},       32'd1);
        chk("t1_overrun", {31'd0, overrun},     32'd0);
        rx_data_ready = 1'b0;
        tick();
        rst = 1'b0;
        model.delete();
        tick();

        // T2: single byte, ready held for 4 clocks
        rx_data       = 8'hA5;
        rx_data_ready = 1'b1;
        tick();
        chk("t2_ack_rise", {31'd0, rx_read_ack}, 32'd1);
        chk("t2_count1",   {27'd0, count},       32'd1);
        chk("t2_rd_data",  {24'd0, rd_data},     32'h0000_00A5);
        chk("t2_empty",    {31'd0, empty},       32'd0);
        tick();
        tick();
        tick();
        chk("t2_one_push", {27'd0, count},       32'd1);
        chk("t2_ack_held", {31'd0, rx_read_ack}, 32'd1);
        rx_data_ready = 1'b0;
        tick();
        chk("t2_ack_fall", {31'd0, rx_read_ack}, 32'd0);
        chk("t2_count2",   {27'd0, count},       32'd1);
        model.push_back(8'hA5);
        pop_byte("t2_pop");
        chk("t2_empty2", {31'd0, empty}, 32'd1);

        // T3: fill 16, 17th byte dropped but acked
        for (int i = 0; i < 16; i++) push_byte(8'(i), "t3_fill");
        chk("t3_full",      {31'd0, full},    32'd1);
        chk("t3_count16",   {27'd0, count},   32'd16);
        chk("t3_no_ovr",    {31'd0, overrun}, 32'd0);
        push_byte(8'h10, "t3_drop");
        chk("t3_overrun",   {31'd0, overrun}, 32'd1);
        chk("t3_count_hold",{27'd0, count},   32'd16);
        for (int i = 0; i < 16; i++) pop_byte("t3_data");
        chk("t3_drained",   {31'd0, empty},   32'd1);
        chk("t3_ovr_sticky",{31'd0, overrun}, 32'd1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("t3_ovr_clr",   {31'd0, overrun}, 32'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t3_rd_empty_cnt", {27'd0, count}, 32'd0);
        chk("t3_rd_empty_flg", {31'd0, empty}, 32'd1);

        // T4: pointer wrap with fill level kept at 4 or below
        max_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            push_byte(8'(i + 'h40), "t4_push");
            chk("t4_count", {27'd0, count}, 32'(model.size()));
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (model.size() == 4) begin
                for (int k = 0; k < 3; k++) pop_byte("t4_data");
            end
        end
        while (model.size() > 0) pop_byte("t4_drain");
        chk("t4_max_le4", {31'd0, (max_cnt <= 4)}, 32'd1);
        chk("t4_empty",   {31'd0, empty},          32'd1);

        // T5: simultaneous push and pop when full, then when empty
        for (int i = 0; i < 16; i++) push_byte(8'(i + 'h20), "t5_fill");
        chk("t5_head", {24'd0, rd_data}, 32'h0000_0020);
        void'(model.pop_front());
        model.push_back(8'h5A);
        rx_data       = 8'h5A;
        rx_data_ready = 1'b1;
        rd_en         = 1'b1;
        tick();
        rd_en         = 1'b0;
        rx_data_ready = 1'b0;
        tick();
        chk("t5_count16", {27'd0, count},   32'd16);
        chk("t5_full",    {31'd0, full},    32'd1);
        chk("t5_no_ovr",  {31'd0, overrun}, 32'd0);
        for (int i = 0; i < 16; i++) pop_byte("t5_data");
        chk("t5_empty",   {31'd0, empty},   32'd1);
        rx_data       = 8'h77;
        rx_data_ready = 1'b1;
        rd_en         = 1'b1;
        tick();
        rd_en         = 1'b0;
        rx_data_ready = 1'b0;
        chk("t5_cnt_from0",  {27'd0, count},   32'd1);
        chk("t5_data_from0", {24'd0, rd_data}, 32'h0000_0077);
        tick();
        model.push_back(8'h77);
        pop_byte("t5_pop77");

`ifdef NEXI_UART_RX_FIFO_IRQ_EN
        // T6: irq from fill level and from overrun alone
        chk("t6_irq_idle", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 3; i++) push_byte(8'(i + 'h60), "t6_p");
        chk("t6_irq_3", {31'd0, irq}, 32'd0);
        push_byte(8'h63, "t6_p4");
        chk("t6_irq_4", {31'd0, irq}, 32'd1);
        pop_byte("t6_pop");
        chk("t6_irq_pop", {31'd0, irq}, 32'd0);
        while (model.size() > 0) pop_byte("t6_drain");
        for (int i = 0; i < 17; i++) push_byte(8'(i + 'h80), "t6_fill");
        while (model.size() > 0) pop_byte("t6_drain2");
        chk("t6_cnt0",    {27'd0, count},   32'd0);
        chk("t6_ovr",     {31'd0, overrun}, 32'd1);
        chk("t6_irq_ovr", {31'd0, irq},     32'd1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("t6_irq_clr", {31'd0, irq},     32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
